sram_responder: RTL

Memory-side responder for the CPU's SRAM request/stall interface. Accepts one request at a time (`req`, `read`, active-low byte write enables, word address, write data) from either the instruction or data port. Holds `stall` high for a programmable number of cycles, then completes the access and presents read data. The top level instantiates two copies: IM with writes tied off, DM with full read/write.

---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_responder_if.sv | 24 ++
 rtl/sram_array.sv | 31 +++
 rtl/sram_responder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM request/stall responder.
// Imported by the responder top and its interface.
package sram_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} sram_state_e;

    localparam logic [3:0] WEB_NONE = 4'hf;

    // Width of the stall counter; supports LATENCY up to 15.
    localparam int unsigned CNT_BITS = 4;

endpackage

// File: rtl/sram_responder_if.sv
// CPU-side SRAM request/stall bus: the requester drives master, the memory drives slave.
interface sram_responder_if #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned WEB_BITS  = 4
);
    logic                 req;
    logic                 read;
    logic [WEB_BITS-1:0]  web;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 stall;

    modport master (
        output req, read, web, addr, wdata,
        input  rdata, stall
    );

    modport slave (
        input  req, read, web, addr, wdata,
        output rdata, stall
    );
endinterface

// File: rtl/sram_array.sv
// Single-port word array: synchronous byte-masked write, synchronous enabled read.
// Contents are not reset.
module sram_array #(
    parameter int unsigned DEPTH     = 16384,
    parameter int unsigned IDX_BITS  = 14,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned WEB_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [IDX_BITS-1:0]  addr,
    input  logic [WEB_BITS-1:0]  web,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);
    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(WEB_BITS); i++) begin
                if (!web[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/sram_responder.sv
// Memory-side responder: accepts one request, stalls LATENCY cycles, performs the
// access on the last stall edge and presents read data in the following RESP cycle.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned WEB_BITS  = 4,
    parameter int unsigned DEPTH     = 16384,
    parameter int unsigned LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_responder_if.slave   bus
);
    localparam int unsigned          IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS:0]   DEPTH_W  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [CNT_BITS-1:0]  CNT_LOAD = CNT_BITS'(LATENCY - 1);

    sram_state_e          state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 read_q;
    logic [WEB_BITS-1:0]  web_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 rdata_zero_q;

    logic                 capture;
    logic                 access;
    logic                 stall_c;
    logic                 use_in;
    logic                 acc_read;
    logic [WEB_BITS-1:0]  acc_web;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [DATA_BITS-1:0] acc_wdata;
    logic                 in_range;
    logic                 wr_en;
    logic                 rd_en;
    logic [DATA_BITS-1:0] arr_rdata;

    // With LATENCY==1 the access happens on the acceptance edge, before capture lands.
    assign use_in    = (state_q == S_IDLE);
    assign acc_read  = use_in ? bus.read  : read_q;
    assign acc_web   = use_in ? bus.web   : web_q;
    assign acc_addr  = use_in ? bus.addr  : addr_q;
    assign acc_wdata = use_in ? bus.wdata : wdata_q;

    assign in_range = ({1'b0, acc_addr} < DEPTH_W);
    assign wr_en    = access & ~acc_read & ~(&acc_web) & in_range;
    assign rd_en    = access & acc_read & in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        stall_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stall_c = bus.req;
                if (bus.req) begin
                    capture = 1'b1;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        access  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset forces stall low even while the requester still holds req.
    assign bus.stall = stall_c & ~rst;
    assign bus.rdata = rdata_zero_q ? '0 : arr_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            read_q       <= 1'b0;
            web_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_zero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                read_q  <= bus.read;
                web_q   <= bus.web;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (access && acc_read) begin
                rdata_zero_q <= ~in_range;
            end
        end
    end

    sram_array #(
        .DEPTH     (DEPTH),
        .IDX_BITS  (IDX_BITS),
        .DATA_BITS (DATA_BITS),
        .WEB_BITS  (WEB_BITS)
    ) u_array (
        .clk   (clk),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (acc_addr[IDX_BITS-1:0]),
        .web   (acc_web),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );
endmodule
